// File: rtl/uart_ocd_loader.sv
// uart_ocd_loader
// Serial (8N1) command receiver that loads words into the RV2T MCU memory
// through the on-chip-debugger write port, and launches the core with a boot PC.
// Frame: 5A <cmd> <addr[7:0]..addr[31:24]> <data[7:0]..data[31:24]>
//   cmd 01 = WRITE word, cmd 02 = START at addr.
`timescale 1ns/1ps

module uart_ocd_loader #(
  parameter int BAUD_DIV      = 434,  // clocks per UART bit, must be >= 8
  parameter int MEM_ADDR_BITS = 16,   // word-address width of the MCU memory
  parameter int XLEN          = 32,   // data word width
  parameter int PC_BITWIDTH   = 32    // boot PC width
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RXD,
  output logic                     ocd_write_enable,
  output logic [MEM_ADDR_BITS-1:0] ocd_rw_addr,
  output logic [XLEN-1:0]          ocd_write_word,
  output logic                     start,
  output logic [PC_BITWIDTH-1:0]   start_address,
  output logic                     frame_error,
  output logic                     busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CMD, P_ADDR, P_DATA} p_state_t;

  // ---------------------------------------------------------------------------
  // Receiver registers
  logic          r_rxd_meta;
  logic          r_rxd_sync;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_rx_shift;
  logic          r_byte_valid;
  logic          r_frame_error;

  // Parser registers
  p_state_t                 r_p_state;
  logic [1:0]               r_byte_idx;
  logic                     r_is_start;
  logic [31:0]              r_addr;
  logic [31:0]              r_data;
  logic                     r_we;
  logic [MEM_ADDR_BITS-1:0] r_rw_addr;
  logic [XLEN-1:0]          r_write_word;
  logic                     r_start;
  logic [PC_BITWIDTH-1:0]   r_start_address;

  // Little-endian assembly: each new byte enters at the top and older bytes
  // move down, so after four bytes the first one sits in [7:0].
  logic [31:0] w_addr_full;
  logic [31:0] w_data_full;
  assign w_addr_full = {r_rx_shift, r_addr[31:8]};
  assign w_data_full = {r_rx_shift, r_data[31:8]};

  // Two-stage synchronizer for the asynchronous RXD line (idles high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // 8N1 receiver: mid-bit sampling driven by a down-counter that expires at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state    <= R_IDLE;
      r_bit_cnt     <= '0;
      r_bit_idx     <= '0;
      r_rx_shift    <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (!r_rxd_sync) begin
            r_rx_state <= R_START;
            r_bit_cnt  <= HALF_LOAD;
          end
        end
        R_START: begin
          if (r_bit_cnt == '0) begin
            if (!r_rxd_sync) begin
              r_rx_state <= R_DATA;
              r_bit_cnt  <= FULL_LOAD;
              r_bit_idx  <= '0;
            end else begin
              // line went back high before mid-start: glitch, not a character
              r_rx_state <= R_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - CW'(1);
          end
        end
        R_DATA: begin
          if (r_bit_cnt == '0) begin
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            r_bit_cnt  <= FULL_LOAD;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= R_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - CW'(1);
          end
        end
        R_STOP: begin
          if (r_bit_cnt == '0) begin
            // leave immediately so a start bit right after the stop is caught
            if (r_rxd_sync) r_byte_valid  <= 1'b1;
            else            r_frame_error <= 1'b1;
            r_rx_state <= R_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt - CW'(1);
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // Command parser: consumes received bytes and issues writes / start requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p_state       <= P_SYNC;
      r_byte_idx      <= '0;
      r_is_start      <= 1'b0;
      r_addr          <= '0;
      r_data          <= '0;
      r_we            <= 1'b0;
      r_rw_addr       <= '0;
      r_write_word    <= '0;
      r_start         <= 1'b0;
      r_start_address <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_frame_error) begin
        // a corrupted character poisons the whole frame
        r_p_state  <= P_SYNC;
        r_byte_idx <= '0;
      end else if (r_byte_valid) begin
        case (r_p_state)
          P_SYNC: begin
            if (r_rx_shift == SYNC_BYTE) r_p_state <= P_CMD;
          end
          P_CMD: begin
            if (r_rx_shift == CMD_WRITE || r_rx_shift == CMD_START) begin
              r_is_start <= (r_rx_shift == CMD_START);
              r_byte_idx <= '0;
              r_p_state  <= P_ADDR;
            end else begin
              r_p_state <= P_SYNC;
            end
          end
          P_ADDR: begin
            r_addr     <= w_addr_full;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) r_p_state <= P_DATA;
          end
          P_DATA: begin
            r_data     <= w_data_full;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_p_state <= P_SYNC;
              if (r_is_start) begin
                // start is sticky; data bytes of a START are don't-care
                r_start         <= 1'b1;
                r_start_address <= r_addr[PC_BITWIDTH-1:0];
              end else begin
                r_we         <= 1'b1;
                r_rw_addr    <= r_addr[MEM_ADDR_BITS+1:2];
                r_write_word <= XLEN'(w_data_full);
              end
            end
          end
          default: r_p_state <= P_SYNC;
        endcase
      end
    end
  end

  assign ocd_write_enable = r_we;
  assign ocd_rw_addr      = r_rw_addr;
  assign ocd_write_word   = r_write_word;
  assign start            = r_start;
  assign start_address    = r_start_address;
  assign frame_error      = r_frame_error;
  // decoded from the parser state register only
  assign busy             = (r_p_state != P_SYNC);

endmodule

// File: tb/tb_uart_ocd_loader.sv
// Testbench for uart_ocd_loader: a byte-level protocol model predicts writes
// and start requests into a queue; a monitor pops and compares on each event.
`timescale 1ns/1ps

module tb_uart_ocd_loader;

  localparam int BAUD = 16;
  localparam int MAB  = 16;
  localparam realtime CLK_NS = 10.0;
  localparam realtime BIT_NS = BAUD * CLK_NS;

  logic           clk = 1'b0;
  logic           reset;
  logic           RXD;
  logic           ocd_write_enable;
  logic [MAB-1:0] ocd_rw_addr;
  logic [31:0]    ocd_write_word;
  logic           start;
  logic [31:0]    start_address;
  logic           frame_error;
  logic           busy;

  uart_ocd_loader #(
    .BAUD_DIV(BAUD), .MEM_ADDR_BITS(MAB), .XLEN(32), .PC_BITWIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .RXD(RXD),
    .ocd_write_enable(ocd_write_enable), .ocd_rw_addr(ocd_rw_addr),
    .ocd_write_word(ocd_write_word), .start(start), .start_address(start_address),
    .frame_error(frame_error), .busy(busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  typedef struct {
    bit          is_start;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pend[$];
  logic [7:0] tx_q[$];
  int total = 0;
  int bad = 0;
  int n_writes = 0;
  int exp_writes = 0;
  int fe_pulses = 0;
  logic prev_start = 1'b0;
  ev_t  mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Protocol model: a frame is 5A, a command of 01/02, then 8 bytes.
  // Leading non-5A bytes are dropped; 5A followed by a bad command drops both.
  function automatic void model_byte(input logic [7:0] b);
    bit again;
    ev_t e;
    pend.push_back(b);
    again = 1'b1;
    while (again) begin
      again = 1'b0;
      if (pend.size() > 0 && pend[0] != 8'h5A) begin
        pend.delete(0);
        again = 1'b1;
      end else if (pend.size() >= 2 && pend[1] != 8'h01 && pend[1] != 8'h02) begin
        pend.delete(0);
        pend.delete(0);
        again = 1'b1;
      end else if (pend.size() == 10) begin
        e.is_start = (pend[1] == 8'h02);
        e.addr = {pend[5], pend[4], pend[3], pend[2]};
        e.data = {pend[9], pend[8], pend[7], pend[6]};
        exp_q.push_back(e);
        if (!e.is_start) exp_writes++;
        pend.delete();
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input realtime bit_ns);
    if (stop_ok) model_byte(b);
    else pend.delete();
    RXD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      #(bit_ns);
    end
    RXD = stop_ok;
    #(bit_ns);
    RXD = 1'b1;
  endtask

  task automatic send_q(input realtime bit_ns, input int max_gap_bits);
    @(negedge clk);
    while (tx_q.size() > 0) begin
      send_byte(tx_q.pop_front(), 1'b1, bit_ns);
      if (max_gap_bits > 0) #(bit_ns * $urandom_range(max_gap_bits, 0));
    end
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    tx_q.push_back(8'h5A);
    tx_q.push_back(cmd);
    for (int i = 0; i < 4; i++) tx_q.push_back(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) tx_q.push_back(data[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every strobe / start rise must match the head of the queue
  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      if (frame_error) fe_pulses++;
      if (ocd_write_enable) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("write_expected", ocd_write_enable, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_kind", 1'b0, mon_e.is_start);
          check("write_addr", ocd_rw_addr, MAB'(mon_e.addr >> 2));
          check("write_data", ocd_write_word, mon_e.data);
          check("busy_at_strobe", busy, 1'b0);
        end
      end
      if (start && !prev_start) begin
        if (exp_q.size() == 0) begin
          check("start_expected", start, prev_start);
        end else begin
          mon_e = exp_q.pop_front();
          check("start_kind", 1'b1, mon_e.is_start);
          check("start_address", start_address, mon_e.addr);
        end
      end
      prev_start = start;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, ocd_write_enable, 0);
    check({tag, "_addr"}, ocd_rw_addr, 0);
    check({tag, "_word"}, ocd_write_word, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_start_addr"}, start_address, 0);
    check({tag, "_ferr"}, frame_error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  g;
    reset = 1'b1;
    RXD   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed WRITE, back-to-back characters
    tx_q = '{8'h5A, 8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
    send_q(BIT_NS, 0);
    wait_drain("write1_drain");
    check("write1_count", n_writes, 1);
    check("write1_word", ocd_write_word, 32'h12345678);
    check("write1_addr_hold", ocd_rw_addr, MAB'(32'h20000004));

    // START, then a WRITE that must still be honoured
    push_frame(8'h02, 32'h80000000, 32'h0);
    send_q(BIT_NS, 0);
    wait_drain("start_drain");
    check("start_level", start, 1'b1);
    check("start_addr_val", start_address, 32'h80000000);
    push_frame(8'h01, 32'h0000_0124, 32'hCAFE_F00D);
    send_q(BIT_NS, 1);
    wait_drain("post_start_drain");
    check("post_start_count", n_writes, 2);
    check("start_sticky", start, 1'b1);

    // Garbage and bad command before a valid frame
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'h07};
    push_frame(8'h01, 32'h0000_0A08, 32'hDEAD_BEEF);
    send_q(BIT_NS, 0);
    wait_drain("garbage_drain");
    check("garbage_count", n_writes, 3);

    // Framing error on the 3rd address byte
    tx_q = '{8'h5A, 8'h01, 8'h44, 8'h33};
    send_q(BIT_NS, 0);
    send_byte(8'h22, 1'b0, BIT_NS);
    #(2 * BIT_NS);
    @(negedge clk);
    check("ferr_pulses", fe_pulses, 1);
    check("ferr_busy", busy, 1'b0);
    check("ferr_no_write", n_writes, 3);
    push_frame(8'h01, 32'h0000_0330, 32'h0BAD_F00D);
    send_q(BIT_NS, 0);
    wait_drain("ferr_recover_drain");
    check("ferr_recover_count", n_writes, 4);

    // False start glitch in the middle of a frame (parser waiting for command)
    tx_q = '{8'h5A};
    send_q(BIT_NS, 0);
    @(negedge clk);
    RXD = 1'b0;
    repeat (3) @(negedge clk);
    RXD = 1'b1;
    repeat (BAUD / 2 + 3 + 4) @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    check("glitch_ferr", fe_pulses, 1);
    tx_q = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(BIT_NS, 0);
    wait_drain("glitch_drain");
    check("glitch_count", n_writes, 5);

    // Reset after 5 bytes of a frame
    tx_q = '{8'h5A, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send_q(BIT_NS, 0);
    check("mid_busy", busy, 1'b1);
    #3;
    reset = 1'b1;
    pend.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midreset_no_write", n_writes, 5);
    push_frame(8'h01, 32'h0000_0550, 32'h5555_AAAA);
    send_q(BIT_NS, 0);
    wait_drain("after_reset_drain");
    check("after_reset_count", n_writes, 6);

    // Baud tolerance: +3 % and -3 % bit period
    push_frame(8'h01, 32'h0000_0660, 32'h0102_0304);
    send_q(BIT_NS * 1.03, 0);
    wait_drain("slow_drain");
    push_frame(8'h01, 32'h0000_0770, 32'hF0E0_D0C0);
    send_q(BIT_NS * 0.97, 0);
    wait_drain("fast_drain");
    check("tolerance_count", n_writes, 8);

    // Randomized frames with garbage, bad commands and idle gaps
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        g = 8'($urandom);
        if (g == 8'h5A) g = 8'h00;
        tx_q.push_back(g);
      end
      if ($urandom_range(3, 0) == 0) begin
        g = 8'($urandom);
        if (g == 8'h01 || g == 8'h02) g = 8'h03;
        tx_q.push_back(8'h5A);
        tx_q.push_back(g);
      end
      a = $urandom;
      d = $urandom;
      push_frame(8'h01, a, d);
      send_q(BIT_NS, 2);
    end
    wait_drain("random_drain");
    check("random_count", n_writes, exp_writes);
    check("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
